// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Record widths are fixed here; the top-level width parameters must match them.
package wb_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 4;

    // R15 is the PC and has no storage in the register file.
    localparam logic [ADDR_W_DEFAULT-1:0] PC_ADDR = 4'hF;

    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] addr;
        logic [DATA_W_DEFAULT-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_HOLD
    } grant_e;

endpackage

// File: rtl/wb_hold_buf.sv
// Single-entry holding register for multiplier results.
// A starve counter tracks lost arbitrations and raises hold_force at STARVE_MAX.
module wb_hold_buf
    import wb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    mul_valid,
    input  wb_req_t mul_req,
    input  logic    hold_gnt,
    output logic    mul_ready,
    output logic    hold_valid,
    output wb_req_t hold_req,
    output logic    hold_force
);

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic    hold_valid_q, hold_valid_d;
    wb_req_t hold_req_q,   hold_req_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        hold_valid_d = hold_valid_q;
        hold_req_d   = hold_req_q;
        starve_cnt_d = starve_cnt_q;

        if (hold_valid_q) begin
            if (hold_gnt) begin
                // Draining cycle: mul_ready is still low, so no refill here.
                hold_valid_d = 1'b0;
                starve_cnt_d = '0;
            end else if (starve_cnt_q != 4'hF) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end else begin
            starve_cnt_d = '0;
            if (mul_valid) begin
                hold_valid_d = 1'b1;
                hold_req_d   = mul_req;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_req_q   <= '0;
            starve_cnt_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_req_q   <= hold_req_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign mul_ready  = !hold_valid_q;
    assign hold_valid = hold_valid_q;
    assign hold_req   = hold_req_q;
    assign hold_force = hold_valid_q && (starve_cnt_q == STARVE_LIMIT);

endmodule

// File: rtl/regfile_wb_arb.sv
// Writeback arbiter owning the register-file write port (we3/wa3/wd3).
// Optional macro WB_BYPASS_EN adds write-to-read forwarding on rd1_byp/rd2_byp.
module regfile_wb_arb
    import wb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mul_valid,
    output logic              mul_ready,
    input  logic [ADDR_W-1:0] mul_addr,
    input  logic [DATA_W-1:0] mul_data,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wd,
    output logic              busy,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1_byp,
    output logic [DATA_W-1:0] rd2_byp
);

    logic    hold_valid;
    logic    hold_force;
    logic    hold_gnt;
    wb_req_t hold_req;
    wb_req_t mul_req;
    wb_req_t alu_req;
    wb_req_t sel_req;
    grant_e  gnt;

    assign mul_req = '{addr: mul_addr, data: mul_data};
    assign alu_req = '{addr: alu_addr, data: alu_data};

    wb_hold_buf #(
        .STARVE_MAX (STARVE_MAX)
    ) u_hold_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .mul_valid  (mul_valid),
        .mul_req    (mul_req),
        .hold_gnt   (hold_gnt),
        .mul_ready  (mul_ready),
        .hold_valid (hold_valid),
        .hold_req   (hold_req),
        .hold_force (hold_force)
    );

    // A starved hold result pre-empts the ALU; alu_ready ignores alu_valid.
    always_comb begin
        gnt       = GNT_NONE;
        alu_ready = !hold_force;
        if (hold_force) begin
            gnt = GNT_HOLD;
        end else if (alu_valid) begin
            gnt = GNT_ALU;
        end else if (hold_valid) begin
            gnt = GNT_HOLD;
        end
    end

    assign hold_gnt = (gnt == GNT_HOLD);
    assign sel_req  = (gnt == GNT_HOLD) ? hold_req : alu_req;

    logic              we3_q,   we3_d;
    logic [ADDR_W-1:0] wa3_q,   wa3_d;
    logic [DATA_W-1:0] wd3_q,   wd3_d;
    logic              pc_we_q, pc_we_d;
    logic [DATA_W-1:0] pc_wd_q, pc_wd_d;

    // R15 writes become PC redirects and leave the file's write port untouched.
    always_comb begin
        we3_d   = 1'b0;
        pc_we_d = 1'b0;
        wa3_d   = wa3_q;
        wd3_d   = wd3_q;
        pc_wd_d = pc_wd_q;
        if (gnt != GNT_NONE) begin
            if (sel_req.addr == PC_ADDR) begin
                pc_we_d = 1'b1;
                pc_wd_d = sel_req.data;
            end else begin
                we3_d = 1'b1;
                wa3_d = sel_req.addr;
                wd3_d = sel_req.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q   <= 1'b0;
            wa3_q   <= '0;
            wd3_q   <= '0;
            pc_we_q <= 1'b0;
            pc_wd_q <= '0;
        end else begin
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
            pc_we_q <= pc_we_d;
            pc_wd_q <= pc_wd_d;
        end
    end

    assign we3   = we3_q;
    assign wa3   = wa3_q;
    assign wd3   = wd3_q;
    assign pc_we = pc_we_q;
    assign pc_wd = pc_wd_q;
    assign busy  = hold_valid;

`ifdef WB_BYPASS_EN
    // Covers the cycle where the write sits on the port but the file is stale.
    assign rd1_byp = (we3_q && (wa3_q == ra1) && (ra1 != PC_ADDR)) ? wd3_q : rf_rd1;
    assign rd2_byp = (we3_q && (wa3_q == ra2) && (ra2 != PC_ADDR)) ? wd3_q : rf_rd2;
`else
    logic unused_ra;
    assign unused_ra = ^{ra1, ra2};
    assign rd1_byp   = rf_rd1;
    assign rd2_byp   = rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed self-checking bench for regfile_wb_arb (STARVE_MAX = 4).
// Bypass expectations follow WB_BYPASS_EN when the bench is built with it.
module tb_regfile_wb_arb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mul_valid;
    logic              mul_ready;
    logic [ADDR_W-1:0] mul_addr;
    logic [DATA_W-1:0] mul_data;
    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] wd3;
    logic              pc_we;
    logic [DATA_W-1:0] pc_wd;
    logic              busy;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1_byp;
    logic [DATA_W-1:0] rd2_byp;

    int checks;
    int failures;

    regfile_wb_arb #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mul_valid (mul_valid),
        .mul_ready (mul_ready),
        .mul_addr  (mul_addr),
        .mul_data  (mul_data),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .pc_we     (pc_we),
        .pc_wd     (pc_wd),
        .busy      (busy),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1_byp   (rd1_byp),
        .rd2_byp   (rd2_byp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL rst_we3 got=%0h exp=0", we3); end
        checks++; if (wa3 !== 4'h0) begin failures++; $display("FAIL rst_wa3 got=%0h exp=0", wa3); end
        checks++; if (wd3 !== 32'h0) begin failures++; $display("FAIL rst_wd3 got=%0h exp=0", wd3); end
        checks++; if (pc_we !== 1'b0) begin failures++; $display("FAIL rst_pc_we got=%0h exp=0", pc_we); end
        checks++; if (pc_wd !== 32'h0) begin failures++; $display("FAIL rst_pc_wd got=%0h exp=0", pc_wd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        checks++; if (mul_ready !== 1'b1) begin failures++; $display("FAIL rst_mul_ready got=%0h exp=1", mul_ready); end
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL rst_alu_ready got=%0h exp=1", alu_ready); end
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'hDEADBEEF;
        #1;
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL alu_ready_pre got=%0h exp=1", alu_ready); end
        cyc();
        alu_valid = 1'b0;
        checks++; if (we3 !== 1'b1) begin failures++; $display("FAIL alu_we3 got=%0h exp=1", we3); end
        checks++; if (wa3 !== 4'd3) begin failures++; $display("FAIL alu_wa3 got=%0h exp=3", wa3); end
        checks++; if (wd3 !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_wd3 got=%0h exp=deadbeef", wd3); end
        checks++; if (pc_we !== 1'b0) begin failures++; $display("FAIL alu_pc_we got=%0h exp=0", pc_we); end
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL alu_ready_post got=%0h exp=1", alu_ready); end
        cyc();
        checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL alu_we3_idle got=%0h exp=0", we3); end
    endtask

    task automatic test_pc_redirect();
        alu_valid = 1'b1; alu_addr = 4'hF; alu_data = 32'h00001008;
        cyc();
        alu_valid = 1'b0;
        checks++; if (pc_we !== 1'b1) begin failures++; $display("FAIL pc_pc_we got=%0h exp=1", pc_we); end
        checks++; if (pc_wd !== 32'h00001008) begin failures++; $display("FAIL pc_pc_wd got=%0h exp=1008", pc_wd); end
        checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL pc_we3 got=%0h exp=0", we3); end
        checks++; if (wa3 !== 4'd3) begin failures++; $display("FAIL pc_wa3_hold got=%0h exp=3", wa3); end
        checks++; if (wd3 !== 32'hDEADBEEF) begin failures++; $display("FAIL pc_wd3_hold got=%0h exp=deadbeef", wd3); end
        cyc();
        checks++; if (pc_we !== 1'b0) begin failures++; $display("FAIL pc_pc_we_idle got=%0h exp=0", pc_we); end
    endtask

    task automatic test_collision();
        logic [ADDR_W-1:0] a;
        mul_valid = 1'b1; mul_addr = 4'd5; mul_data = 32'h55;
        #1;
        checks++; if (mul_ready !== 1'b1) begin failures++; $display("FAIL col_mul_ready_pre got=%0h exp=1", mul_ready); end
        cyc();
        mul_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL col_busy got=%0h exp=1", busy); end
        checks++; if (mul_ready !== 1'b0) begin failures++; $display("FAIL col_mul_ready got=%0h exp=0", mul_ready); end
        for (int k = 0; k < 4; k++) begin
            a = ADDR_W'(8 + k);
            alu_valid = 1'b1; alu_addr = a; alu_data = 32'hA0 + 32'(k);
            #1;
            checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL col_alu_ready_%0d got=%0h exp=1", k, alu_ready); end
            cyc();
            checks++; if ({we3, wa3, wd3} !== {1'b1, a, 32'hA0 + 32'(k)})
                begin failures++; $display("FAIL col_alu_wr_%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, we3, wa3, wd3, a, 32'hA0 + 32'(k)); end
        end
        alu_valid = 1'b1; alu_addr = 4'd12; alu_data = 32'hC0;
        #1;
        checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL col_force_alu_ready got=%0h exp=0", alu_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL col_force_busy got=%0h exp=1", busy); end
        cyc();
        checks++; if ({we3, wa3, wd3} !== {1'b1, 4'd5, 32'h55})
            begin failures++; $display("FAIL col_mul_wr got=%0h/%0h/%0h exp=1/5/55", we3, wa3, wd3); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL col_busy_drop got=%0h exp=0", busy); end
        checks++; if (mul_ready !== 1'b1) begin failures++; $display("FAIL col_mul_ready_back got=%0h exp=1", mul_ready); end
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL col_alu_ready_back got=%0h exp=1", alu_ready); end
        cyc();
        alu_valid = 1'b0;
        checks++; if ({we3, wa3, wd3} !== {1'b1, 4'd12, 32'hC0})
            begin failures++; $display("FAIL col_alu_retry got=%0h/%0h/%0h exp=1/c/c0", we3, wa3, wd3); end
        cyc();
    endtask

    task automatic test_idle_drain();
        mul_valid = 1'b1; mul_addr = 4'd7; mul_data = 32'h77;
        cyc();
        mul_valid = 1'b0;
        checks++; if (mul_ready !== 1'b0) begin failures++; $display("FAIL drn_mul_ready got=%0h exp=0", mul_ready); end
        checks++; if (we3 !== 1'b0) begin failures++; $display("FAIL drn_we3_early got=%0h exp=0", we3); end
        cyc();
        checks++; if (mul_ready !== 1'b1) begin failures++; $display("FAIL drn_mul_ready_back got=%0h exp=1", mul_ready); end
        checks++; if ({we3, wa3, wd3} !== {1'b1, 4'd7, 32'h77})
            begin failures++; $display("FAIL drn_wr got=%0h/%0h/%0h exp=1/7/77", we3, wa3, wd3); end
        cyc();
    endtask

    task automatic test_back_to_back();
        alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 32'h1;
        cyc();
        alu_data = 32'h2;
        checks++; if ({we3, wa3, wd3} !== {1'b1, 4'd6, 32'h1})
            begin failures++; $display("FAIL b2b_first got=%0h/%0h/%0h exp=1/6/1", we3, wa3, wd3); end
        cyc();
        alu_valid = 1'b0;
        checks++; if ({we3, wa3, wd3} !== {1'b1, 4'd6, 32'h2})
            begin failures++; $display("FAIL b2b_second got=%0h/%0h/%0h exp=1/6/2", we3, wa3, wd3); end
        cyc();
    endtask

    task automatic test_reset_mid_hold();
        mul_valid = 1'b1; mul_addr = 4'd9; mul_data = 32'h99;
        alu_valid = 1'b1; alu_addr = 4'd4; alu_data = 32'h44;
        cyc();
        mul_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmh_busy_pre got=%0h exp=1", busy); end
        checks++; if (we3 !== 1'b1) begin failures++; $display("FAIL rmh_we3_pre got=%0h exp=1", we3); end
        #2;
        rst_n = 1'b0;
        #1;
        test_reset();
        alu_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            checks++; if ({we3, pc_we, busy} !== 3'b000)
                begin failures++; $display("FAIL rmh_ghost_%0d got=%0b exp=000", k, {we3, pc_we, busy}); end
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp1;
        alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 32'h1234;
        cyc();
        alu_valid = 1'b0;
        ra1 = 4'd2; rf_rd1 = 32'h0; ra2 = 4'd3; rf_rd2 = 32'hABCD;
        #1;
`ifdef WB_BYPASS_EN
        exp1 = 32'h1234;
`else
        exp1 = 32'h0;
`endif
        checks++; if (rd1_byp !== exp1) begin failures++; $display("FAIL byp_rd1 got=%0h exp=%0h", rd1_byp, exp1); end
        checks++; if (rd2_byp !== 32'hABCD) begin failures++; $display("FAIL byp_rd2 got=%0h exp=abcd", rd2_byp); end
        ra1 = 4'hF; rf_rd1 = 32'h5555;
        #1;
        checks++; if (rd1_byp !== 32'h5555) begin failures++; $display("FAIL byp_rd1_r15 got=%0h exp=5555", rd1_byp); end
        cyc();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mul_valid = 1'b0; mul_addr = '0; mul_data = '0;
        rf_rd1    = '0;   rf_rd2   = '0; ra1 = '0; ra2 = '0;
        #3;
        test_reset();
        #9;
        rst_n = 1'b1;
        cyc();
        test_alu_only();
        test_pc_redirect();
        test_collision();
        test_idle_drain();
        test_back_to_back();
        test_reset_mid_hold();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
